// File: rtl/ibex_register_file_dump_reader_if.sv
// Bus bundle for the register file dump reader: the register file read port
// on one side and the (address, data) beat stream towards the consumer on
// the other. The dump reader drives through the master modport.
interface ibex_register_file_dump_reader_if #(
    parameter int unsigned DataWidth = 32
);
    // register file read port
    logic                 rf_req_o;
    logic                 rf_gnt_i;
    logic [4:0]           raddr_o;
    logic [DataWidth-1:0] rdata_i;

    // beat stream towards the debug/trace consumer
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [4:0]           out_addr_o;
    logic [DataWidth-1:0] out_data_o;
    logic                 out_last_o;

    modport master (
        output rf_req_o,
        output raddr_o,
        input  rf_gnt_i,
        input  rdata_i,
        output out_valid_o,
        output out_addr_o,
        output out_data_o,
        output out_last_o,
        input  out_ready_i
    );

    modport slave (
        input  rf_req_o,
        input  raddr_o,
        output rf_gnt_i,
        output rdata_i,
        input  out_valid_o,
        input  out_addr_o,
        input  out_data_o,
        input  out_last_o,
        output out_ready_i
    );
endinterface

// File: rtl/ibex_register_file_dump_reader.sv
// Walks the register file through one shared read port and streams each
// register out as an (address, data) beat. A fetch holds the port only until
// it is granted; the captured beat is then held in registers until the
// consumer accepts it, so the port is never held across a consumer stall.
module ibex_register_file_dump_reader #(
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned DataWidth = 32,
    parameter bit          SkipZero  = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic abort_i,
    output logic busy_o,
    output logic done_o,
    ibex_register_file_dump_reader_if.master rf_bus
);

    localparam logic [4:0] LastIdx  = RV32E ? 5'd15 : 5'd31;
    localparam logic [4:0] FirstIdx = SkipZero ? 5'd1 : 5'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2
    } state_e;

    state_e               state_q,    state_d;
    logic [4:0]           index_q,    index_d;
    logic [4:0]           out_addr_q, out_addr_d;
    logic [DataWidth-1:0] out_data_q, out_data_d;
    logic                 out_last_q, out_last_d;
    logic                 done_q,     done_d;

    // Next-state and capture logic; abort takes priority over any progress.
    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_FETCH;
                    index_d = FirstIdx;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                    index_d = 5'd0;
                end else if (rf_bus.rf_gnt_i) begin
                    out_data_d = rf_bus.rdata_i;
                    out_addr_d = index_q;
                    out_last_d = (index_q == LastIdx);
                    state_d    = ST_SEND;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_SEND: begin
                if (abort_i) begin
                    // A beat handshaking in this cycle still counts as sent,
                    // but the dump ends here without a completion pulse.
                    state_d = ST_IDLE;
                    index_d = 5'd0;
                end else if (rf_bus.out_ready_i) begin
                    if (out_last_q) begin
                        // Leave before incrementing so the index never wraps.
                        state_d = ST_IDLE;
                        index_d = 5'd0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                        index_d = index_q + 5'd1;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
                index_d = 5'd0;
            end
        endcase
    end

    // State, index, beat and completion registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            index_q    <= 5'd0;
            out_addr_q <= 5'd0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
            done_q     <= done_d;
        end
    end

    // All outputs are decoded from registers only, never from out_ready_i.
    assign busy_o             = (state_q != ST_IDLE);
    assign done_o             = done_q;
    assign rf_bus.rf_req_o    = (state_q == ST_FETCH);
    assign rf_bus.raddr_o     = (state_q == ST_FETCH) ? index_q : 5'd0;
    assign rf_bus.out_valid_o = (state_q == ST_SEND);
    assign rf_bus.out_addr_o  = out_addr_q;
    assign rf_bus.out_data_o  = out_data_q;
    assign rf_bus.out_last_o  = out_last_q;

endmodule
